// File: rtl/alu_mul_seq.sv
// Sequential unsigned WIDTHxWIDTH shift-add multiplier that borrows the shared ALU adder.
// Optional early termination when the remaining multiplier bits are zero: define MUL_EARLY_TERM_EN.
module alu_mul_seq #(
    parameter int         WIDTH    = 32,
    parameter int         CNT_W    = 6,
    parameter logic [3:0] ADD_CTRL = 4'b0010
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     mcand_i,
    input  logic [WIDTH-1:0]     mplier_i,
    output logic [WIDTH-1:0]     alu_src1_o,
    output logic [WIDTH-1:0]     alu_src2_o,
    output logic [3:0]           alu_ctrl_o,
    output logic [2:0]           alu_bonus_o,
    input  logic [WIDTH-1:0]     alu_result_i,
    input  logic                 alu_cout_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   hi, lo, mcand;
    logic [CNT_W-1:0]   cnt;

    logic               c;
    logic [WIDTH-1:0]   s, hi_nxt, lo_nxt;
    logic [2*WIDTH-1:0] prod_nxt;
    logic               finish;

    // The ALU only sees our operands while we own the mux; otherwise it is fed zeros.
    assign alu_src1_o  = (state == CALC) ? hi       : '0;
    assign alu_src2_o  = (state == CALC) ? mcand    : '0;
    assign alu_ctrl_o  = (state == CALC) ? ADD_CTRL : 4'd0;
    assign alu_bonus_o = 3'd0;

    // The ALU sum (with its carry as bit WIDTH) is consumed in the same cycle it is driven.
    always_comb begin
        if (lo[0]) {c, s} = {alu_cout_i, alu_result_i};
        else       {c, s} = {1'b0, hi};
        hi_nxt = {c, s[WIDTH-1:1]};
        lo_nxt = {s[0], lo[WIDTH-1:1]};
    end

`ifdef MUL_EARLY_TERM_EN
    logic [CNT_W-1:0] rem;
    logic [WIDTH-1:0] rem_mask;
    logic             early;

    // Once the unconsumed multiplier bits are all zero, the remaining iterations are pure
    // shifts, so align the partial product directly.
    assign rem      = CNT_W'(WIDTH-1) - cnt;
    assign rem_mask = (WIDTH'(1) << rem) - WIDTH'(1);
    assign early    = (rem != '0) && ((lo_nxt & rem_mask) == '0);
    assign prod_nxt = {hi_nxt, lo_nxt} >> rem;
    assign finish   = (cnt == CNT_W'(WIDTH-1)) || early;
`else
    assign prod_nxt = {hi_nxt, lo_nxt};
    assign finish   = (cnt == CNT_W'(WIDTH-1));
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            hi        <= '0;
            lo        <= '0;
            mcand     <= '0;
            cnt       <= '0;
            product_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mcand  <= mcand_i;
                        lo     <= mplier_i;
                        hi     <= '0;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (finish) begin
                        product_o <= prod_nxt;
                        done_o    <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done_o <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized self-checking bench for alu_mul_seq; a behavioural adder stands in for the ALU.
module tb_alu_mul_seq;

`ifdef MUL_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk, rst, start;
    logic [31:0] mcand, mplier;
    logic [31:0] alu_src1, alu_src2, alu_result;
    logic [3:0]  alu_ctrl;
    logic [2:0]  alu_bonus;
    logic        alu_cout, busy, done;
    logic [63:0] product;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    alu_mul_seq dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .mcand_i(mcand), .mplier_i(mplier),
        .alu_src1_o(alu_src1), .alu_src2_o(alu_src2),
        .alu_ctrl_o(alu_ctrl), .alu_bonus_o(alu_bonus),
        .alu_result_i(alu_result), .alu_cout_i(alu_cout),
        .busy_o(busy), .done_o(done), .product_o(product)
    );

    // Stand-in ALU: only ADD is modelled.
    always_comb begin
        if (alu_ctrl == 4'b0010 && alu_bonus == 3'd0)
            {alu_cout, alu_result} = {1'b0, alu_src1} + {1'b0, alu_src2};
        else
            {alu_cout, alu_result} = 33'd0;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // Number of edges after the accepting edge until done_o is seen high.
    function automatic int ref_edges(input logic [31:0] b);
        int len = 0;
        for (int i = 0; i < 32; i++) if (b[i]) len = i + 1;
        if (!EARLY) return 32;
        return (len < 1) ? 1 : len;
    endfunction

    // Called at a negedge; waits for IDLE, issues one multiply, returns at the DONE negedge.
    task automatic do_mul(input logic [31:0] a, input logic [31:0] b, output int edges,
                          output logic [63:0] prod, output int ctrl_bad, output int acc_cyc);
        int guard = 0;
        while (busy && guard < 100) begin @(negedge clk); guard++; end
        start = 1'b1; mcand = a; mplier = b;
        @(posedge clk); @(negedge clk);
        start = 1'b0; mcand = $urandom; mplier = $urandom;
        acc_cyc = cyc; edges = -1; prod = '0; ctrl_bad = 0;
        for (int n = 1; n <= 60; n++) begin
            if (!busy || alu_ctrl !== 4'b0010 || alu_bonus !== 3'd0 || alu_src2 !== a) ctrl_bad++;
            @(posedge clk); @(negedge clk);
            if (done) begin edges = n; prod = product; break; end
        end
    endtask

    task automatic test_reset();
        #2;
        vectors++;
        if ({busy, done} !== 2'b00 || product !== 64'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%b done=%b product=%h want 0/0/0", busy, done, product);
        end
        vectors++;
        if (alu_src1 !== 32'd0 || alu_src2 !== 32'd0 || alu_ctrl !== 4'd0 || alu_bonus !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_alu_drive: src1=%h src2=%h ctrl=%h bonus=%h want 0", alu_src1, alu_src2, alu_ctrl, alu_bonus);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int e, cb, ac; logic [63:0] p;
        do_mul(32'd3, 32'd5, e, p, cb, ac);
        vectors++;
        if (e !== ref_edges(32'd5)) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", e, ref_edges(32'd5)); end
        vectors++;
        if (p !== 64'h0000_0000_0000_000F) begin miscompares++; $display("FAIL basic_product: got %h want %h", p, 64'hF); end
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy_in_done: got %b want 1", busy); end
        @(posedge clk); @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL basic_idle_after: busy=%b done=%b want 0/0", busy, done); end
    endtask

    task automatic test_carry();
        int e, cb, ac; logic [63:0] p;
        do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, e, p, cb, ac);
        vectors++;
        if (p !== 64'hFFFF_FFFE_0000_0001) begin miscompares++; $display("FAIL carry_product: got %h want %h", p, 64'hFFFF_FFFE_0000_0001); end
        vectors++;
        if (cb !== 0) begin miscompares++; $display("FAIL carry_alu_ctrl: %0d bad CALC cycles, want 0", cb); end
        vectors++;
        if (e !== 32) begin miscompares++; $display("FAIL carry_latency: got %0d want 32", e); end
    endtask

    task automatic test_zero();
        int e, cb, ac; logic [63:0] p;
        do_mul(32'h1234_5678, 32'd0, e, p, cb, ac);
        vectors++;
        if (p !== 64'd0) begin miscompares++; $display("FAIL zero_product: got %h want 0", p); end
        vectors++;
        if (e !== (EARLY ? 1 : 32)) begin miscompares++; $display("FAIL zero_latency: got %0d want %0d", e, EARLY ? 1 : 32); end
    endtask

    task automatic test_start_while_busy();
        int off, dones = 0, first = -1;
        logic [63:0] p = '0;
        off = EARLY ? 2 : 10;
        while (busy) @(negedge clk);
        start = 1'b1; mcand = 32'd7; mplier = 32'd9;
        @(posedge clk); @(negedge clk);
        for (int n = 1; n <= 80; n++) begin
            if (n == off) begin start = 1'b1; mcand = 32'd2; mplier = 32'd2; end
            else start = 1'b0;
            @(posedge clk); @(negedge clk);
            if (done) begin dones++; if (first < 0) begin first = n; p = product; end end
        end
        start = 1'b0;
        vectors++;
        if (dones !== 1) begin miscompares++; $display("FAIL busy_done_count: got %0d want 1", dones); end
        vectors++;
        if (first !== ref_edges(32'd9)) begin miscompares++; $display("FAIL busy_latency: got %0d want %0d", first, ref_edges(32'd9)); end
        vectors++;
        if (p !== 64'd63) begin miscompares++; $display("FAIL busy_product: got %h want 63", p); end
    endtask

    task automatic test_reset_mid();
        int dones = 0, e, cb, ac; logic [63:0] p;
        start = 1'b1; mcand = 32'd100; mplier = EARLY ? 32'h8000_0064 : 32'd100;
        @(posedge clk); @(negedge clk); start = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++;
        if ({busy, done} !== 2'b00 || product !== 64'd0) begin
            miscompares++;
            $display("FAIL midreset_async: busy=%b done=%b product=%h want 0/0/0", busy, done, product);
        end
        @(negedge clk); rst = 1'b0;
        for (int n = 0; n < 40; n++) begin @(posedge clk); @(negedge clk); if (done || busy) dones++; end
        vectors++;
        if (dones !== 0) begin miscompares++; $display("FAIL midreset_no_done: %0d active cycles, want 0", dones); end
        do_mul(32'd6, 32'd7, e, p, cb, ac);
        vectors++;
        if (p !== 64'd42) begin miscompares++; $display("FAIL midreset_fresh: got %h want 42", p); end
    endtask

    task automatic test_latency();
        int e, cb, ac; logic [63:0] p;
        do_mul(32'd7, 32'd3, e, p, cb, ac);
        vectors++;
        if (e !== (EARLY ? 2 : 32)) begin miscompares++; $display("FAIL lat_small_edges: got %0d want %0d", e, EARLY ? 2 : 32); end
        vectors++;
        if (p !== 64'd21) begin miscompares++; $display("FAIL lat_small_product: got %h want 21", p); end
        do_mul(32'd2, 32'h8000_0000, e, p, cb, ac);
        vectors++;
        if (e !== 32) begin miscompares++; $display("FAIL lat_msb_edges: got %0d want 32", e); end
        vectors++;
        if (p !== 64'h0000_0001_0000_0000) begin miscompares++; $display("FAIL lat_msb_product: got %h want %h", p, 64'h1_0000_0000); end
    endtask

    task automatic test_random();
        int e, cb, ac; logic [63:0] p; logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = (i % 6 == 0) ? 32'hFFFF_FFFF : $urandom;
            b = $urandom >> $urandom_range(0, 31);
            do_mul(a, b, e, p, cb, ac);
            vectors++;
            if (p !== ref_prod(a, b) || e !== ref_edges(b) || cb !== 0) begin
                miscompares++;
                $display("FAIL random_%0d: %h*%h got %h/%0d edges/%0d badctl want %h/%0d/0",
                         i, a, b, p, e, cb, ref_prod(a, b), ref_edges(b));
            end
        end
    endtask

    task automatic test_back_to_back();
        int e1, e2, cb, ac1, ac2; logic [63:0] p1, p2; logic [31:0] a2, b2;
        a2 = $urandom; b2 = $urandom | 32'h8000_0000;
        do_mul(32'hDEAD_BEEF, 32'h0000_1234, e1, p1, cb, ac1);
        // Request held high through the DONE cycle must only be taken in the following IDLE cycle.
        start = 1'b1; mcand = a2; mplier = b2;
        do_mul(a2, b2, e2, p2, cb, ac2);
        vectors++;
        if (ac2 - ac1 !== ref_edges(32'h0000_1234) + 2) begin
            miscompares++; $display("FAIL b2b_interval: got %0d want %0d", ac2 - ac1, ref_edges(32'h0000_1234) + 2);
        end
        vectors++;
        if (p1 !== ref_prod(32'hDEAD_BEEF, 32'h0000_1234)) begin miscompares++; $display("FAIL b2b_first: got %h want %h", p1, ref_prod(32'hDEAD_BEEF, 32'h1234)); end
        vectors++;
        if (p2 !== ref_prod(a2, b2) || e2 !== 32) begin miscompares++; $display("FAIL b2b_second: got %h/%0d want %h/32", p2, e2, ref_prod(a2, b2)); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        test_reset();
        test_basic();
        test_carry();
        test_zero();
        test_start_while_busy();
        test_reset_mid();
        test_latency();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_mul_seq.md
Name: alu_mul_seq

Overview:
- Multi-cycle unsigned 32x32 multiply sequencer for the shared 32-bit ALU.
- Uses a shift-add loop: drives the ALU's src1/src2/ALU_control/bonus_control ports, then samples the ALU's result and cout in the same cycle.
- Produces a registered 64-bit product.
- Sits beside the ALU in the execute stage; while busy=1 the sequencer owns the ALU operand mux.

Parameters:
- WIDTH, 32, operand width; must match the ALU width.
- CNT_W, 6, iteration counter width; needs ceil(log2(WIDTH))+1 bits.
- ADD_CTRL, 4'b0010, ALU_control code for ADD (A_invert=0, B_invert=0, cin=0, operation=10).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  request a multiply; sampled only in IDLE.
- mcand_i  in  WIDTH  multiplicand; captured when start_i is accepted.
- mplier_i  in  WIDTH  multiplier; captured when start_i is accepted.
- alu_src1_o  out  WIDTH  to ALU src1; the current high partial product.
- alu_src2_o  out  WIDTH  to ALU src2; the latched multiplicand.
- alu_ctrl_o  out  4  to ALU_control.
- alu_bonus_o  out  3  to bonus_control.
- alu_result_i  in  WIDTH  from ALU result.
- alu_cout_i  in  1  from ALU cout.
- busy_o  out  1  high in CALC and DONE.
- done_o  out  1  one-cycle pulse; product_o is valid in that cycle.
- product_o  out  2*WIDTH  registered product; held until the next accepted start.

Behaviour:
- Reset: state=IDLE; hi, lo, mcand, cnt, product_o = 0; busy_o=0; done_o=0.
- Reset is asynchronous and overrides everything, including mid-operation. A multiply interrupted by reset is abandoned and no done is issued.
- ALU drive:
  - In CALC: alu_ctrl_o=ADD_CTRL, alu_bonus_o=3'd0, alu_src1_o=hi, alu_src2_o=mcand.
  - In IDLE and DONE: all four ALU outputs are 0.
- IDLE:
  - start_i=1 loads mcand=mcand_i, lo=mplier_i, hi=0, cnt=0, then goes to CALC.
  - start_i=0 stays in IDLE.
- CALC, one iteration per cycle:
  - If lo[0]=1: {c,s} = {alu_cout_i, alu_result_i}; otherwise {c,s} = {0, hi}.
  - Next {hi,lo} = {c, s, lo[WIDTH-1:1]}, a 65-bit logical right shift by 1.
  - cnt increments.
  - When cnt==WIDTH-1 at the clock edge, go to DONE.
  - The ALU is combinational: its result is consumed in the same cycle it is driven. The sequencer adds no wait states.
- DONE:
  - done_o=1 and busy_o=1 for exactly one cycle.
  - product_o={hi,lo}, registered on the CALC->DONE edge so it is valid during DONE.
  - Next state is IDLE.
- Latency: the start edge is E0 and CALC covers E1..E32. done_o is high in the cycle following edge E32, i.e. 33 edges after start.
  - Back-to-back: the earliest next start is sampled in the IDLE cycle after DONE. Minimum issue interval is 34 cycles.
- start_i while busy_o=1 is ignored. It is not queued and mcand/lo/hi are not disturbed.
- Operand inputs are don't-care except on the accepting edge.
- Arithmetic is unsigned only. The full 64-bit product never overflows, so there is no overflow flag.
- alu_cout_i supplies bit WIDTH of each partial sum. It is required for correct results with large operands.

Optional Feature:
- Macro MUL_EARLY_TERM_EN.
- Defined:
  - In CALC, after the current iteration's update, let r = WIDTH-1-cnt, the number of iterations remaining.
  - If r>0 and the low r bits of the new lo are all zero, go directly to DONE.
  - On that edge, load product_o = {hi_new, lo_new} >> r.
  - done_o timing is otherwise unchanged: one cycle, then IDLE.
- Not defined:
  - Always exactly WIDTH CALC cycles.
  - The comparator and barrel-shift logic is absent.
- In both builds, product_o values must be identical for all operands.

Test Plan:
- Basic multiply: reset; start with mcand=3, mplier=5 -> done_o pulses 33 edges after start; product_o=64'h0000_0000_0000_000F; busy_o low again one cycle later.
- Carry path: mcand=32'hFFFF_FFFF, mplier=32'hFFFF_FFFF -> product_o=64'hFFFF_FFFE_0000_0001. Also check alu_ctrl_o=4'b0010 and alu_bonus_o=0 every CALC cycle.
- Zero operand: mcand=32'h1234_5678, mplier=0 -> product_o=0. Without MUL_EARLY_TERM_EN, done still comes at 33 edges. With it, done comes 2 edges after start.
- Start while busy: start at t0 with 7*9; pulse start with 2*2 at t0+10 -> only one done_o, at t0+33, with product_o=63. The second request is dropped.
- Reset mid-operation: start 100*100; assert rst_i asynchronously at t0+15, between clock edges -> busy_o, done_o and product_o go to 0 immediately. No done follows. A fresh start 6*7 afterwards gives 42.
- Early termination (MUL_EARLY_TERM_EN defined): mplier=3, mcand=7 -> done_o 3 edges after start, product_o=21. Repeat with mplier=32'h8000_0000, mcand=2 -> full 33-edge latency, product_o=64'h0000_0001_0000_0000.
